// File: rtl/conv_core_engine.sv
// Linear convolution engine: Z[n] = sum_k X[k]*Y[n-k], one MAC per two cycles.
// CONV_CORE_SAT_EN selects signed operands with a wide accumulator and saturated output.
module conv_core_engine #(
  parameter int DATA_W = 32,
  parameter int AX_W   = 5,
  parameter int AZ_W   = 6
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              en_s,
  input  logic              start,
  input  logic [AX_W-1:0]   size_x,
  input  logic [AX_W-1:0]   size_y,
  output logic              rd_x,
  output logic [AX_W-1:0]   addr_x,
  input  logic [DATA_W-1:0] data_x,
  output logic              rd_y,
  output logic [AX_W-1:0]   addr_y,
  input  logic [DATA_W-1:0] data_y,
  output logic              we_z,
  output logic [AZ_W-1:0]   addr_z,
  output logic [DATA_W-1:0] data_z,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_MAC, S_WRITE, S_DONE
  } state_t;

  localparam logic [AX_W-1:0] X_ONE = {{(AX_W-1){1'b0}}, 1'b1};
  localparam logic [AZ_W-1:0] Z_ONE = {{(AZ_W-1){1'b0}}, 1'b1};
  localparam logic [AZ_W-1:0] Z_TWO = {{(AZ_W-2){1'b0}}, 2'b10};

  state_t            r_state, w_state_nxt;
  logic [AX_W-1:0]   r_sx, r_sy, r_k, r_kmax;
  logic [AZ_W-1:0]   r_n;
  logic [AX_W-1:0]   w_kmin, w_kmax;
  logic [AZ_W-1:0]   w_sx_ext, w_sy_ext;
  logic              w_last_n, w_last_k, w_zero;
  logic [DATA_W-1:0] w_result;

`ifdef CONV_CORE_SAT_EN
  localparam int ACC_W = 2*DATA_W + AX_W;
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0]    r_acc, w_acc_nxt;
  logic signed [2*DATA_W-1:0] w_xs, w_ys, w_prod;

  assign w_xs      = $signed(data_x);
  assign w_ys      = $signed(data_y);
  assign w_prod    = w_xs * w_ys;
  assign w_acc_nxt = r_acc + w_prod;

  always_comb begin
    if (r_acc > SMAX)      w_result = SMAX[DATA_W-1:0];
    else if (r_acc < SMIN) w_result = SMIN[DATA_W-1:0];
    else                   w_result = r_acc[DATA_W-1:0];
  end
`else
  logic [DATA_W-1:0] r_acc, w_acc_nxt;

  assign w_acc_nxt = r_acc + data_x * data_y;
  assign w_result  = r_acc;
`endif

  assign w_sx_ext = {{(AZ_W-AX_W){1'b0}}, r_sx};
  assign w_sy_ext = {{(AZ_W-AX_W){1'b0}}, r_sy};
  assign w_zero   = (size_x == '0) || (size_y == '0);
  assign w_last_n = (r_n == w_sx_ext + w_sy_ext - Z_TWO);
  assign w_last_k = (r_k == r_kmax);

  // Both bounds fit in AX_W bits, so modular AX_W arithmetic gives exact values.
  assign w_kmin = (r_n >= w_sy_ext) ? (r_n[AX_W-1:0] + X_ONE - r_sy) : '0;
  assign w_kmax = (r_n <  w_sx_ext) ? r_n[AX_W-1:0] : (r_sx - X_ONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_zero ? S_DONE : S_SETUP;
      S_SETUP: w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_MAC;
      S_MAC:   w_state_nxt = w_last_k ? S_WRITE : S_FETCH;
      S_WRITE: w_state_nxt = w_last_n ? S_DONE : S_SETUP;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      r_state <= S_IDLE;
      r_sx    <= '0;
      r_sy    <= '0;
      r_k     <= '0;
      r_kmax  <= '0;
      r_n     <= '0;
      r_acc   <= '0;
    end else if (en_s) begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (start) begin
          r_sx <= size_x;
          r_sy <= size_y;
          r_n  <= '0;
        end
        S_SETUP: begin
          r_k    <= w_kmin;
          r_kmax <= w_kmax;
          r_acc  <= '0;
        end
        S_MAC: begin
          r_acc <= w_acc_nxt;
          if (!w_last_k) r_k <= r_k + X_ONE;
        end
        S_WRITE: if (!w_last_n) r_n <= r_n + Z_ONE;
        default: ;
      endcase
    end
  end

  // Strobes are gated by en_s so a frozen engine never touches memory.
  always_comb begin
    rd_x   = 1'b0;
    rd_y   = 1'b0;
    addr_x = '0;
    addr_y = '0;
    we_z   = 1'b0;
    addr_z = '0;
    data_z = '0;
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
    if (r_state == S_FETCH) begin
      rd_x   = en_s;
      rd_y   = en_s;
      addr_x = r_k;
      addr_y = r_n[AX_W-1:0] - r_k;
    end
    if (r_state == S_WRITE) begin
      we_z   = en_s;
      addr_z = r_n;
      data_z = w_result;
    end
  end

endmodule
